// File: rtl/instr_chain_encoder.sv
// Serialises one high-level chain request into a V_RD..END_CHAIN stream of
// 24-bit {opcode, op1, op2} instructions for the decoder, with valid/ready on both sides.
//
// state   | meaning
// --------+---------------------------------------------
// S_IDLE  | waiting for a request, req_ready=1
// S_VRD   | presenting V_RD {vec_mem_id, vrf_rd_addr}
// S_MRD   | presenting M_RD {mat_mem_id, mrf_rd_addr}
// S_MVMUL | presenting MV_MUL
// S_ELT   | presenting VV_ADD/VV_MUL/VV_SUB (skipped if none)
// S_ACT   | presenting V_RELU/V_SIGM/V_TANH (skipped if none)
// S_VWR   | presenting V_WR {out_mem_id, vrf_wr_addr}
// S_END   | presenting END_CHAIN
module instr_chain_encoder #(
  parameter int OPCODE_WIDTH = 4,
  parameter int VRF_AWIDTH   = 10,
  parameter int MRF_AWIDTH   = 10,
  parameter int MEM_ID_WIDTH = 4,
  parameter int INSTR_WIDTH  = OPCODE_WIDTH + 2*VRF_AWIDTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [MEM_ID_WIDTH-1:0] req_vec_mem_id,
  input  logic [VRF_AWIDTH-1:0]   req_vrf_rd_addr,
  input  logic [MEM_ID_WIDTH-1:0] req_mat_mem_id,
  input  logic [MRF_AWIDTH-1:0]   req_mrf_rd_addr,
  input  logic [1:0]              req_eltwise,
  input  logic [1:0]              req_act,
  input  logic [MEM_ID_WIDTH-1:0] req_out_mem_id,
  input  logic [VRF_AWIDTH-1:0]   req_vrf_wr_addr,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_WIDTH-1:0]  instruction,
  output logic                    busy,
  output logic                    chain_done,
  output logic [15:0]             issued_count
);

  localparam logic [OPCODE_WIDTH-1:0] OP_V_RD      = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_V_WR      = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_M_RD      = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_MV_MUL    = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_VV_ADD    = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_VV_SUB    = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_VV_MUL    = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_V_RELU    = 4'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_V_SIGM    = 4'd10;
  localparam logic [OPCODE_WIDTH-1:0] OP_V_TANH    = 4'd11;
  localparam logic [OPCODE_WIDTH-1:0] OP_END_CHAIN = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE, S_VRD, S_MRD, S_MVMUL, S_ELT, S_ACT, S_VWR, S_END
  } state_t;

  state_t state, nxt_state;
  logic [INSTR_WIDTH-1:0]  nxt_word;
  logic [MEM_ID_WIDTH-1:0] mat_mem_id_q, out_mem_id_q;
  logic [MRF_AWIDTH-1:0]   mrf_rd_addr_q;
  logic [VRF_AWIDTH-1:0]   vrf_wr_addr_q;
  logic [1:0]              eltwise_q, act_q;

  // op1 carries the mem id zero-extended to the VRF address width
  function automatic logic [INSTR_WIDTH-1:0] pack(input logic [OPCODE_WIDTH-1:0] opc,
                                                  input logic [MEM_ID_WIDTH-1:0] id,
                                                  input logic [VRF_AWIDTH-1:0]   addr);
    return {opc, {(VRF_AWIDTH-MEM_ID_WIDTH){1'b0}}, id, addr};
  endfunction

  function automatic logic [OPCODE_WIDTH-1:0] elt_op(input logic [1:0] sel);
    case (sel)
      2'b01:   return OP_VV_ADD;
      2'b10:   return OP_VV_MUL;
      default: return OP_VV_SUB;
    endcase
  endfunction

  function automatic logic [OPCODE_WIDTH-1:0] act_op(input logic [1:0] sel);
    case (sel)
      2'b01:   return OP_V_RELU;
      2'b10:   return OP_V_SIGM;
      default: return OP_V_TANH;
    endcase
  endfunction

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Word to present after a handshake in the current state
  always_comb begin
    nxt_state = S_END;
    nxt_word  = pack(OP_END_CHAIN, '0, '0);
    case (state)
      S_VRD: begin
        nxt_state = S_MRD;
        nxt_word  = pack(OP_M_RD, mat_mem_id_q, mrf_rd_addr_q);
      end
      S_MRD: begin
        nxt_state = S_MVMUL;
        nxt_word  = pack(OP_MV_MUL, '0, '0);
      end
      S_MVMUL: begin
        if (eltwise_q != 2'b00) begin
          nxt_state = S_ELT;
          nxt_word  = pack(elt_op(eltwise_q), '0, '0);
        end else if (act_q != 2'b00) begin
          nxt_state = S_ACT;
          nxt_word  = pack(act_op(act_q), '0, '0);
        end else begin
          nxt_state = S_VWR;
          nxt_word  = pack(OP_V_WR, out_mem_id_q, vrf_wr_addr_q);
        end
      end
      S_ELT: begin
        if (act_q != 2'b00) begin
          nxt_state = S_ACT;
          nxt_word  = pack(act_op(act_q), '0, '0);
        end else begin
          nxt_state = S_VWR;
          nxt_word  = pack(OP_V_WR, out_mem_id_q, vrf_wr_addr_q);
        end
      end
      S_ACT: begin
        nxt_state = S_VWR;
        nxt_word  = pack(OP_V_WR, out_mem_id_q, vrf_wr_addr_q);
      end
      default: begin
        nxt_state = S_END;
        nxt_word  = pack(OP_END_CHAIN, '0, '0);
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      instr_valid   <= 1'b0;
      instruction   <= '0;
      chain_done    <= 1'b0;
      issued_count  <= '0;
      mat_mem_id_q  <= '0;
      mrf_rd_addr_q <= '0;
      eltwise_q     <= '0;
      act_q         <= '0;
      out_mem_id_q  <= '0;
      vrf_wr_addr_q <= '0;
    end else begin
      chain_done <= 1'b0;
      if (state == S_IDLE) begin
        if (req_valid) begin
          // V_RD fields go straight into the instruction register
          mat_mem_id_q  <= req_mat_mem_id;
          mrf_rd_addr_q <= req_mrf_rd_addr;
          eltwise_q     <= req_eltwise;
          act_q         <= req_act;
          out_mem_id_q  <= req_out_mem_id;
          vrf_wr_addr_q <= req_vrf_wr_addr;
          state         <= S_VRD;
          instr_valid   <= 1'b1;
          instruction   <= pack(OP_V_RD, req_vec_mem_id, req_vrf_rd_addr);
        end
      end else if (instr_valid && instr_ready) begin
        issued_count <= issued_count + 16'd1;
        if (state == S_END) begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          instruction <= '0;
          chain_done  <= 1'b1;
        end else begin
          state       <= nxt_state;
          instruction <= nxt_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_chain_encoder.sv
// Directed bench for instr_chain_encoder: reset, chain shapes, backpressure,
// back-to-back requests and mid-chain reset, with hand-computed instruction words.
module tb_instr_chain_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_vec_mem_id;
  logic [9:0]  req_vrf_rd_addr;
  logic [3:0]  req_mat_mem_id;
  logic [9:0]  req_mrf_rd_addr;
  logic [1:0]  req_eltwise;
  logic [1:0]  req_act;
  logic [3:0]  req_out_mem_id;
  logic [9:0]  req_vrf_wr_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instruction;
  logic        busy;
  logic        chain_done;
  logic [15:0] issued_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_chain_encoder dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_vec_mem_id(req_vec_mem_id), .req_vrf_rd_addr(req_vrf_rd_addr),
    .req_mat_mem_id(req_mat_mem_id), .req_mrf_rd_addr(req_mrf_rd_addr),
    .req_eltwise(req_eltwise), .req_act(req_act),
    .req_out_mem_id(req_out_mem_id), .req_vrf_wr_addr(req_vrf_wr_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
    .busy(busy), .chain_done(chain_done), .issued_count(issued_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] vm, input logic [9:0] vr, input logic [3:0] mm,
                         input logic [9:0] mr, input logic [1:0] e, input logic [1:0] a,
                         input logic [3:0] om, input logic [9:0] vw);
    req_vec_mem_id  = vm;  req_vrf_rd_addr = vr;
    req_mat_mem_id  = mm;  req_mrf_rd_addr = mr;
    req_eltwise     = e;   req_act         = a;
    req_out_mem_id  = om;  req_vrf_wr_addr = vw;
  endtask

  task automatic test_reset;
    resetn = 1'b0; req_valid = 1'b0; instr_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    checks++;
    if ({instr_valid, busy, chain_done, instruction} !== 27'd0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b busy=%b done=%b instr=%h, want 0/0/0/000000",
               instr_valid, busy, chain_done, instruction);
    end
    resetn = 1'b1;
    tick();
    checks++;
    if ({req_ready, instr_valid, chain_done, issued_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b done=%b cnt=%0d, want 1/0/0/0",
               req_ready, instr_valid, chain_done, issued_count);
    end
    for (int i = 0; i < 4; i++) begin
      instr_ready = ~instr_ready;
      tick();
      checks++;
      if ({instr_valid, busy, issued_count} !== 18'd0) begin
        errors++;
        $display("FAIL idle_ready_toggle[%0d]: valid=%b busy=%b cnt=%0d, want 0/0/0",
                 i, instr_valid, busy, issued_count);
      end
    end
  endtask

  task automatic test_basic_chain;
    logic [23:0] exp [0:5];
    exp = '{24'h000C05, 24'h200810, 24'h400000, 24'h900000, 24'h100420, 24'hC00000};
    instr_ready = 1'b1;
    set_req(4'd3, 10'h005, 4'd2, 10'h010, 2'b00, 2'b01, 4'd1, 10'h020);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({instr_valid, instruction} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL basic_word[%0d]: valid=%b instr=%h, want 1 %h", i, instr_valid, instruction, exp[i]);
      end
      tick();
    end
    checks++;
    if ({chain_done, instr_valid, req_ready, busy, issued_count} !== {4'b1010, 16'd6}) begin
      errors++;
      $display("FAIL basic_done: done=%b valid=%b ready=%b busy=%b cnt=%0d, want 1/0/1/0/6",
               chain_done, instr_valid, req_ready, busy, issued_count);
    end
    tick();
    checks++;
    if (chain_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b, want 0", chain_done);
    end
  endtask

  task automatic test_full_chain;
    logic [23:0] exp [0:6];
    exp = '{24'h000C05, 24'h200810, 24'h400000, 24'h600000, 24'hB00000, 24'h100420, 24'hC00000};
    instr_ready = 1'b1;
    set_req(4'd3, 10'h005, 4'd2, 10'h010, 2'b11, 2'b11, 4'd1, 10'h020);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({instr_valid, instruction} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL full_word[%0d]: valid=%b instr=%h, want 1 %h", i, instr_valid, instruction, exp[i]);
      end
      tick();
    end
    checks++;
    if ({chain_done, instr_valid, issued_count} !== {2'b10, 16'd13}) begin
      errors++;
      $display("FAIL full_done: done=%b valid=%b cnt=%0d, want 1/0/13", chain_done, instr_valid, issued_count);
    end
    tick();
  endtask

  task automatic test_backpressure;
    logic [23:0] exp [0:5];
    exp = '{24'h000C05, 24'h200810, 24'h400000, 24'h900000, 24'h100420, 24'hC00000};
    instr_ready = 1'b1;
    set_req(4'd3, 10'h005, 4'd2, 10'h010, 2'b00, 2'b01, 4'd1, 10'h020);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({instr_valid, instruction} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL bp_word[%0d]: valid=%b instr=%h, want 1 %h", i, instr_valid, instruction, exp[i]);
      end
      if (i == 1) begin
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++;
          if ({instr_valid, instruction, issued_count} !== {1'b1, 24'h200810, 16'd14}) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b instr=%h cnt=%0d, want 1 200810 14",
                     k, instr_valid, instruction, issued_count);
          end
        end
        instr_ready = 1'b1;
      end
      tick();
    end
    checks++;
    if ({chain_done, issued_count} !== {1'b1, 16'd19}) begin
      errors++;
      $display("FAIL bp_done: done=%b cnt=%0d, want 1/19", chain_done, issued_count);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp_a [0:5];
    logic [23:0] exp_b [0:4];
    exp_a = '{24'h000C05, 24'h200810, 24'h400000, 24'h900000, 24'h100420, 24'hC00000};
    exp_b = '{24'h0017FF, 24'h203C01, 24'h400000, 24'h800000, 24'h1003FE};
    instr_ready = 1'b1;
    set_req(4'd3, 10'h005, 4'd2, 10'h010, 2'b00, 2'b01, 4'd1, 10'h020);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({instr_valid, instruction} !== {1'b1, exp_a[i]}) begin
        errors++;
        $display("FAIL b2b_a_word[%0d]: valid=%b instr=%h, want 1 %h", i, instr_valid, instruction, exp_a[i]);
      end
      if (i == 2) begin
        set_req(4'd5, 10'h3FF, 4'd15, 10'h001, 2'b10, 2'b00, 4'd0, 10'h3FE);
        req_valid = 1'b1;
        checks++;
        if ({req_ready, busy} !== 2'b01) begin
          errors++;
          $display("FAIL b2b_busy: ready=%b busy=%b, want 0/1", req_ready, busy);
        end
      end
      tick();
    end
    checks++;
    if ({chain_done, req_ready, instr_valid} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_done: done=%b ready=%b valid=%b, want 1/1/0", chain_done, req_ready, instr_valid);
    end
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({instr_valid, instruction} !== {1'b1, exp_b[i]}) begin
        errors++;
        $display("FAIL b2b_b_word[%0d]: valid=%b instr=%h, want 1 %h", i, instr_valid, instruction, exp_b[i]);
      end
      tick();
    end
    checks++;
    if ({instr_valid, instruction} !== {1'b1, 24'hC00000}) begin
      errors++;
      $display("FAIL b2b_b_end: valid=%b instr=%h, want 1 c00000", instr_valid, instruction);
    end
    tick();
    checks++;
    if ({chain_done, issued_count} !== {1'b1, 16'd31}) begin
      errors++;
      $display("FAIL b2b_b_done: done=%b cnt=%0d, want 1/31", chain_done, issued_count);
    end
    tick();
  endtask

  task automatic test_mid_reset;
    int seen_valid;
    instr_ready = 1'b1;
    set_req(4'd3, 10'h005, 4'd2, 10'h010, 2'b00, 2'b01, 4'd1, 10'h020);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if ({instr_valid, instruction} !== {1'b1, 24'h400000}) begin
      errors++;
      $display("FAIL mid_reset_pre: valid=%b instr=%h, want 1 400000", instr_valid, instruction);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({instr_valid, busy, chain_done, issued_count, instruction} !== 43'd0) begin
      errors++;
      $display("FAIL mid_reset_async: valid=%b busy=%b done=%b cnt=%0d instr=%h, want all 0",
               instr_valid, busy, chain_done, issued_count, instruction);
    end
    tick();
    resetn = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (instr_valid !== 1'b0 || chain_done !== 1'b0) seen_valid++;
    end
    checks++;
    if (seen_valid != 0 || req_ready !== 1'b1 || issued_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_after: stray_cycles=%0d ready=%b cnt=%0d, want 0/1/0",
               seen_valid, req_ready, issued_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_chain();
    test_full_chain();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_chain_encoder.md
Name: instr_chain_encoder

Overview:
- Issue-side counterpart of the instruction decoder. Accepts one high-level "chain" request per handshake and serialises it into a stream of 24-bit instructions {opcode[23:20], op1[19:10], op2[9:0]} for the decoder.
- Sits between the host/control sequencer and the decoder input.
- Uses a valid/ready handshake on both sides and pulses a completion flag after END_CHAIN is accepted.

Parameters:
- INSTR_WIDTH, 24, instruction width (OPCODE_WIDTH+2*VRF_AWIDTH).
- OPCODE_WIDTH, 4, opcode field width.
- VRF_AWIDTH, 10, VRF address width; also the op1/op2 field width.
- MRF_AWIDTH, 10, MRF address width (must equal VRF_AWIDTH).
- MEM_ID_WIDTH, 4, memory-id width; zero-extended into op1.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  chain request valid.
- req_ready  out  1  encoder can accept a request.
- req_vec_mem_id  in  MEM_ID_WIDTH  source vector memory id.
- req_vrf_rd_addr  in  VRF_AWIDTH  source VRF read address.
- req_mat_mem_id  in  MEM_ID_WIDTH  matrix memory id.
- req_mrf_rd_addr  in  MRF_AWIDTH  MRF read address.
- req_eltwise  in  2  00 none, 01 VV_ADD, 10 VV_MUL, 11 VV_SUB.
- req_act  in  2  00 none, 01 V_RELU, 10 V_SIGM, 11 V_TANH.
- req_out_mem_id  in  MEM_ID_WIDTH  destination memory id.
- req_vrf_wr_addr  in  VRF_AWIDTH  destination VRF write address.
- instr_valid  out  1  instruction valid.
- instr_ready  in  1  decoder side accepts the instruction.
- instruction  out  INSTR_WIDTH  encoded instruction.
- busy  out  1  chain in progress (state != IDLE).
- chain_done  out  1  one-cycle pulse after END_CHAIN is accepted.
- issued_count  out  16  wrapping count of accepted instructions.

Behaviour:
- Reset (async, resetn=0): state=IDLE, instr_valid=0, instruction=0, busy=0, chain_done=0, issued_count=0, request latches=0. req_ready=1 as soon as resetn deasserts.
- Opcodes: V_RD=0, V_WR=1, M_RD=2, MV_MUL=4, VV_ADD=5, VV_SUB=6, VV_MUL=8, V_RELU=9, V_SIGM=10, V_TANH=11, END_CHAIN=12.
- req_ready = (state==IDLE). A request is accepted on the clk edge where req_valid&&req_ready; all request fields are latched on that edge.
- States: IDLE -> S_VRD -> S_MRD -> S_MVMUL -> [S_ELT] -> [S_ACT] -> S_VWR -> S_END -> IDLE.
  - S_ELT is skipped when eltwise==00; S_ACT is skipped when act==00.
  - Each non-IDLE state emits exactly one instruction.
  - The state advances only on instr_valid&&instr_ready.
- Encodings (op1 = zero-extended mem id):
  - S_VRD: {0, vec_mem_id, vrf_rd_addr}.
  - S_MRD: {2, mat_mem_id, mrf_rd_addr}.
  - S_MVMUL: {4, 0, 0}.
  - S_ELT: {5/8/6, 0, 0}.
  - S_ACT: {9/10/11, 0, 0}.
  - S_VWR: {1, out_mem_id, vrf_wr_addr}.
  - S_END: {12, 0, 0}.
- instruction and instr_valid are registered.
  - Request accepted at edge N -> instr_valid=1 with the V_RD word from N+1.
  - Each following word is presented the cycle after the previous handshake, with no bubble: instr_valid stays 1 across consecutive words.
- While instr_valid&&!instr_ready, instruction is held stable and instr_valid does not drop.
- After the END_CHAIN handshake:
  - instr_valid=0 and chain_done=1 for exactly the next cycle.
  - state=IDLE, so req_ready=1 in that same cycle. A new request can be accepted then; its V_RD appears the cycle after.
- issued_count increments by 1 on every instr handshake and wraps 0xFFFF->0.
- Chain length is 5..7 instructions.
- req_valid while busy is ignored; no latching, no state change.
- instr_ready while instr_valid=0 has no effect.
- Reset mid-chain aborts immediately. No END_CHAIN is emitted, outputs return to reset values, and the latched request is discarded.

Test Plan:
- Reset/idle: hold resetn=0 then release -> instr_valid=0, req_ready=1, issued_count=0, chain_done=0; toggling instr_ready causes no change.
- Basic chain, instr_ready=1: vec_mem=3, vrf_rd=0x005, mat=2, mrf=0x010, eltwise=00, act=01, out_mem=1, vrf_wr=0x020.
  - Expect on consecutive cycles: 0x000C05, 0x200810, 0x400000, 0x900000, 0x100420, 0xC00000.
  - Then chain_done pulses 1 cycle; issued_count=6.
- Full chain, eltwise=11, act=11 -> 7 words with 0x600000 after MV_MUL and 0xB00000 before V_WR; issued_count=7.
- Backpressure: instr_ready low 3 cycles during the M_RD word -> 0x200810 held stable with instr_valid=1 throughout; no skipped or duplicated words.
- Busy/back-to-back: second req_valid during the chain is ignored (req_ready=0). It is accepted in the chain_done cycle, and its V_RD appears the next cycle.
- Mid-chain reset: assert resetn=0 during S_MVMUL -> instr_valid=0 and busy=0 immediately; issued_count=0; no 0xC00000 issued.
